// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if: valid/ready handshake carrying encoded register-transfer instructions
// Signals: valid (producer has an instruction), data (11-bit instruction), ready (sequencer FIFO can accept)
interface datapath_sequencer_if;
  logic        valid;
  logic [10:0] data;
  logic        ready;
  modport master (output valid, data, input ready);
  modport slave (input valid, data, output ready);
endinterface

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: buffers instructions in a FIFO and issues one per cycle onto the Datapath controls
// Ports: clk; reset (sync, active-low); instr (slave handshake in); run (permits issue);
//   src_reg1_addr/src_reg2_addr/dest_reg_addr/alu_op/reg_write (registered Datapath controls);
//   alu_result (sampled for capture); captured_result/capture_valid (last capture, one-cycle pulse);
//   busy (work pending or issuing); count (FIFO occupancy)
module datapath_sequencer #(
  parameter int DEPTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  datapath_sequencer_if.slave     instr,
  input  logic                    run,
  output logic [1:0]              src_reg1_addr,
  output logic [1:0]              src_reg2_addr,
  output logic [1:0]              dest_reg_addr,
  output logic [2:0]              alu_op,
  output logic                    reg_write,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  output logic [DATA_WIDTH-1:0]   captured_result,
  output logic                    capture_valid,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [0:0]    state;
  logic          capture_pending, push, pop;
  // DEPTH is a power of two, so the count MSB alone marks a full FIFO
  assign instr.ready = reset && !count[AW];
  assign push = instr.valid && instr.ready;
  assign pop = run && count != '0;
  assign busy = count != '0 || state == ISSUE;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= instr.data;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      state <= IDLE;
      {dest_reg_addr, src_reg1_addr, src_reg2_addr, alu_op, reg_write, capture_pending} <= '0;
      captured_result <= '0;
      capture_valid <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + CW'(push) - CW'(pop);
      state <= pop ? ISSUE : IDLE;
      // field order of the instruction word matches this concatenation exactly
      {dest_reg_addr, src_reg1_addr, src_reg2_addr, alu_op, reg_write, capture_pending} <= pop ? mem[rd_ptr] : '0;
      // the edge ending a capturing ISSUE cycle samples the Datapath result
      capture_valid <= state == ISSUE && capture_pending;
      if (state == ISSUE && capture_pending) captured_result <= alu_result;
    end
  end
endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Hardware control source for the register-file/ALU `Datapath`. It accepts encoded register-transfer instructions over a valid/ready handshake and buffers them in a small FIFO. It issues one instruction per cycle onto the Datapath control inputs (`srcReg1Addr`, `srcReg2Addr`, `destRegAddr`, `aluOp`, `regWrite`). On request it captures the resulting `aluResult`. It replaces hand-sequenced bench stimulus, so that programs such as "R1←0, R0←−1, R2←R1−1, R3←R0+1" run as instruction streams.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DATA_WIDTH`, 8: width of `aluResult` and `capturedResult`.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; 0 at a rising edge resets the block.
- `instrValid` in 1: producer presents an instruction.
- `instrData` in 11: fields `[10:9]` dest, `[8:7]` src1, `[6:5]` src2, `[4:2]` aluOp, `[1]` regWrite, `[0]` capture.
- `instrReady` out 1: FIFO can accept.
- `run` in 1: 1 permits issue; 0 pauses issue (FIFO keeps filling).
- `srcReg1Addr`, `srcReg2Addr`, `destRegAddr` out 2 each: Datapath register addresses.
- `aluOp` out 3: Datapath ALU operation.
- `regWrite` out 1: Datapath write enable.
- `aluResult` in DATA_WIDTH: Datapath combinational ALU output.
- `capturedResult` out DATA_WIDTH: last captured ALU result.
- `captureValid` out 1: one-cycle pulse when `capturedResult` updates.
- `busy` out 1: FIFO non-empty or state ISSUE.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- A push occurs on an edge where `instrValid && instrReady`. `instrReady = reset && (count < DEPTH)`. It is computed from current occupancy only. A full FIFO does not accept, even if a pop occurs on the same edge.
- There is no bypass. An instruction pushed into an empty FIFO becomes poppable on the next edge.
- FSM states:
  - IDLE: control outputs 0, `regWrite` 0.
  - ISSUE: registered control outputs hold one instruction for exactly one cycle.
- Transitions, evaluated each edge:
  - IDLE→ISSUE when `run && count!=0`: pop, load outputs.
  - ISSUE→ISSUE when `run && count!=0`: pop next, load outputs; back-to-back issue, no bubble.
  - ISSUE→IDLE otherwise: all control outputs 0.
- `regWrite` is the instruction's bit [1] during its ISSUE cycle and 0 in all other cycles. The Datapath commits the write on the edge ending the ISSUE cycle. The next instruction therefore reads the updated register with no hazard logic.
- Capture: if the issuing instruction has bit [0]=1, `aluResult` is sampled on the edge ending its ISSUE cycle. `captureValid` is 1 for the following cycle only. `capturedResult` holds until the next capture.
- Simultaneous push and pop: count unchanged; both take effect.
- FIFO pointers wrap modulo DEPTH; order is strictly FIFO.

## Timing
- Reset (reset=0 at edge) sets the following on the next cycle:
  - FIFO flushed, count 0.
  - State IDLE.
  - All control outputs 0.
  - `capturedResult` 0, `captureValid` 0, `busy` 0.
  - `instrReady` 0 while reset=0.
- Reset mid-ISSUE aborts. Outputs are 0 on the following cycle, and no further `regWrite`.
- Latency: an instruction pushed at edge k with `run`=1 and the FIFO empty appears on the outputs in the cycle after edge k+1.
- Throughput: 1 instruction/cycle while `run`=1 and the FIFO is non-empty.
- Deasserting `run` during ISSUE: the current instruction completes its cycle; the next cycle is IDLE with count unchanged.
- `busy` = (count!=0) || (state==ISSUE).

## Test plan
- Reset: reset=0 for 2 cycles with `instrValid`=1 → count 0, all outputs 0, `instrReady` 0; after release, `instrReady`=1 and the push succeeds.
- Single issue: run=1, push 11'b01_00_00_001_1_0 → two edges later, one cycle with destRegAddr=1, src1=0, src2=0, aluOp=1, regWrite=1, then all 0; busy falls.
- Full/ordering: run=0, push 4 distinct instructions, then a 5th → count=4, `instrReady`=0, 5th dropped; run=1 → 4 consecutive regWrite=1 cycles in push order, then IDLE, count 0.
- Capture: push instruction with bit0=1, drive aluResult=8'hFF during its ISSUE cycle and 8'h00 after → capturedResult=8'hFF, captureValid high exactly one cycle, value held afterwards.
- Pause: 3 queued, run dropped after the first issue → regWrite 0, count 2 held; run=1 → remaining 2 issue back-to-back.
- Reset mid-stream: 3 queued, reset=0 during the second ISSUE → next cycle outputs 0, count 0, third instruction never issued.
